// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: byte width and the frame arbiter state encoding.
package eth_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request found scanning
// circularly upward from the index just after `last`.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] win
);

   always_comb begin
      int   idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && req[IDX_W'(idx)]) begin
            win[IDX_W'(idx)] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin multiplexer of NUM_REQ byte-stream requesters onto one MAC TX stream,
// with truncation at MAX_LEN (remainder drained) and a fixed inter-frame gap.
module tx_frame_arbiter
   import eth_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int MAX_LEN    = 1500,
   parameter int GAP_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      pcs_locked,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_eof,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_eof,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      truncated,
   output logic [15:0]               trunc_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   arb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] win;
   logic [IDX_W-1:0]   win_idx, grant_idx, last;
   logic [LEN_W-1:0]   len_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [BYTE_W-1:0]  req_bytes [NUM_REQ];
   logic               g_valid, g_eof, len_at_last, out_beat, start, frame_end;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req  (req_valid),
      .last (last),
      .win  (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win[i]) win_idx = IDX_W'(i);
   end

   assign g_valid     = req_valid[grant_idx];
   assign g_eof       = req_eof[grant_idx];
   assign len_at_last = (len_cnt == LEN_LAST);
   assign out_beat    = tx_valid && tx_ready;
   assign start       = (state == ST_IDLE) && pcs_locked && (|req_valid);
   // In DRAIN the requester beat ends the frame since req_ready is held high there.
   assign frame_end   = ((state == ST_PASS) && out_beat && g_eof) ||
                        ((state == ST_DRAIN) && g_valid && g_eof);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_PASS;
         ST_PASS:  if (out_beat && !g_eof && len_at_last) state_nxt = ST_DRAIN;
         ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
         default:  ;
      endcase
      if (frame_end) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_eof    = 1'b0;
      req_ready = '0;
      truncated = 1'b0;
      case (state)
         ST_PASS: begin
            tx_valid             = g_valid;
            tx_data              = req_bytes[grant_idx];
            tx_eof               = g_valid && (g_eof || len_at_last);
            req_ready[grant_idx] = tx_ready;
            truncated            = g_valid && tx_ready && !g_eof && len_at_last;
         end
         ST_DRAIN: req_ready[grant_idx] = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant       <= '0;
         grant_idx   <= '0;
         last        <= IDX_W'(NUM_REQ - 1);
         len_cnt     <= '0;
         gap_cnt     <= '0;
         trunc_count <= '0;
      end else begin
         if (start) begin
            grant     <= win;
            grant_idx <= win_idx;
            len_cnt   <= '0;
         end
         if ((state == ST_PASS) && out_beat) len_cnt <= len_cnt + LEN_W'(1);
         if (truncated) trunc_count <= sat_inc16(trunc_count);
         if (frame_end) begin
            last    <= grant_idx;
            grant   <= '0;
            gap_cnt <= GAP_LOAD;
         end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_tx_frame_arbiter;

   localparam int N  = 3;
   localparam int ML = 8;
   localparam int GC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset_n, pcs_locked, tx_valid, tx_eof, tx_ready, truncated;
   logic [N-1:0]   req_valid, req_eof, req_ready, grant;
   logic [N*8-1:0] req_data;
   logic [7:0]     tx_data;
   logic [15:0]    trunc_count;

   logic [1:0]  t_valid, t_eof, t_ready, t_grant;
   logic [15:0] t_data, t_tcount;
   logic        t_tx_valid, t_tx_eof, t_tx_ready, t_trunc;
   logic [7:0]  t_tx_data;

   tx_frame_arbiter #(.NUM_REQ(N), .MAX_LEN(ML), .GAP_CYCLES(GC)) dut (
      .clk(clk), .reset_n(reset_n), .pcs_locked(pcs_locked),
      .req_valid(req_valid), .req_data(req_data), .req_eof(req_eof), .req_ready(req_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_eof(tx_eof), .tx_ready(tx_ready),
      .grant(grant), .truncated(truncated), .trunc_count(trunc_count));

   tx_frame_arbiter #(.NUM_REQ(2), .MAX_LEN(4), .GAP_CYCLES(0)) dut_t (
      .clk(clk), .reset_n(reset_n), .pcs_locked(1'b1),
      .req_valid(t_valid), .req_data(t_data), .req_eof(t_eof), .req_ready(t_ready),
      .tx_valid(t_tx_valid), .tx_data(t_tx_data), .tx_eof(t_tx_eof), .tx_ready(t_tx_ready),
      .grant(t_grant), .truncated(t_trunc), .trunc_count(t_tcount));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // Source byte queues: bit 8 marks the last byte of a frame.
   logic [8:0] srcq [N][$];
   logic [7:0] txlog [$];
   int obs_eofs;

   // Reference model: who owns the stream, bytes sent, draining, gap cycles left.
   int m_owner, m_last, m_len, m_gap, m_tc;
   bit m_drain;

   task automatic model_reset();
      m_owner = -1; m_last = N - 1; m_len = 0; m_gap = 0; m_tc = 0; m_drain = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; pcs_locked = 1'b0; tx_ready = 1'b0;
      req_valid = '0; req_data = '0; req_eof = '0;
      t_valid = '0; t_data = '0; t_eof = '0; t_tx_ready = 1'b0;
      for (int i = 0; i < N; i++) srcq[i].delete();
      txlog.delete();
      obs_eofs = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
   endtask

   task automatic step(input bit txr, input bit lock, input int vpct);
      logic [N-1:0]   rv, re, e_gnt, e_rdy;
      logic [N*8-1:0] rd;
      logic [8:0]     hd;
      bit e_tv, e_eof, e_tr, cur_eof, at_limit, beat, found;
      rv = '0; re = '0; rd = '0;
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0) begin
            hd = srcq[i][0];
            rd[i*8 +: 8] = hd[7:0];
            re[i] = hd[8];
            rv[i] = ($urandom_range(99) < vpct);
         end
      end
      req_valid = rv; req_data = rd; req_eof = re; tx_ready = txr; pcs_locked = lock;
      @(negedge clk);
      e_gnt = '0; e_rdy = '0; e_tv = 0; e_eof = 0; e_tr = 0; cur_eof = 0;
      at_limit = (m_len + 1 == ML);
      if (m_owner >= 0) begin
         e_gnt   = N'(1 << m_owner);
         cur_eof = re[m_owner];
         if (m_drain) e_rdy = N'(1 << m_owner);
         else begin
            e_rdy = txr ? N'(1 << m_owner) : '0;
            e_tv  = rv[m_owner];
            e_eof = e_tv && (cur_eof || at_limit);
            e_tr  = e_tv && txr && at_limit && !cur_eof;
         end
      end
      chk("valid_eof_trunc", {tx_valid, tx_eof, truncated}, {e_tv, e_eof, e_tr});
      chk("grant", grant, e_gnt);
      chk("req_ready", req_ready, e_rdy);
      chk("trunc_count", trunc_count, 16'(m_tc));
      if (e_tv) chk("tx_data", tx_data, rd[m_owner*8 +: 8]);
      if (tx_valid && tx_ready && tx_eof) obs_eofs++;
      beat = e_tv && txr;
      if (beat) txlog.push_back(rd[m_owner*8 +: 8]);
      for (int i = 0; i < N; i++)
         if (rv[i] && e_rdy[i]) void'(srcq[i].pop_front());
      if (m_owner < 0) begin
         if (m_gap > 0) m_gap--;
         else if (lock && (|rv)) begin
            found = 0;
            for (int k = 1; k <= N; k++)
               if (!found && rv[(m_last + k) % N]) begin
                  m_owner = (m_last + k) % N; found = 1;
               end
            m_len = 0; m_drain = 0;
         end
      end else if (!m_drain) begin
         if (beat) begin
            m_len++;
            if (cur_eof) begin
               m_last = m_owner; m_owner = -1; m_gap = GC;
            end else if (at_limit) begin
               m_drain = 1;
               if (m_tc < 65535) m_tc++;
            end
         end
      end else if (rv[m_owner] && cur_eof) begin
         m_last = m_owner; m_owner = -1; m_gap = GC;
      end
      @(posedge clk); #1;
   endtask

   task automatic push_frame(input int r, input logic [7:0] first, input int len);
      for (int j = 0; j < len; j++) srcq[r].push_back({(j == len - 1), first + 8'(j)});
   endtask

   typedef struct packed {
      logic [2:0] rv;  logic [7:0] d;   logic eof;  logic txr;
      logic e_tv;      logic [7:0] e_d; logic e_eof;
      logic [2:0] e_gnt; logic [2:0] e_rdy;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mkv(logic [2:0] rv, logic [7:0] d, logic eof,
                                logic e_tv, logic e_eof, logic [2:0] e_gnt);
      vec_t v;
      v.rv = rv; v.d = d; v.eof = eof; v.txr = 1'b1;
      v.e_tv = e_tv; v.e_d = d; v.e_eof = e_eof; v.e_gnt = e_gnt;
      v.e_rdy = e_gnt;
      return v;
   endfunction

   logic [7:0] exp_c [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
   int exp_trunc, exp_frames, exp_bytes, cyc, len;
   bit busy;

   initial begin
      reset_n = 1'b0; pcs_locked = 1'b0; tx_ready = 1'b0;
      req_valid = '0; req_data = '0; req_eof = '0;
      t_valid = '0; t_data = '0; t_eof = '0; t_tx_ready = 1'b0;
      #7;
      chk("reset_outputs", {tx_valid, tx_eof, truncated, tx_data, grant, req_ready, trunc_count}, '0);
      chk("reset_outputs_t", {t_tx_valid, t_tx_eof, t_trunc, t_tx_data, t_grant, t_ready, t_tcount}, '0);

      // Single frame 01..05, then a second frame offered during the gap.
      tbl[0] = mkv(3'b001, 8'h01, 0, 0, 0, 3'b000);
      for (int i = 1; i <= 5; i++) tbl[i] = mkv(3'b001, 8'(i), (i == 5), 1, (i == 5), 3'b001);
      for (int i = 6; i <= 10; i++) tbl[i] = mkv(3'b001, 8'hAA, 0, 0, 0, 3'b000);
      tbl[11] = mkv(3'b001, 8'hAA, 0, 1, 0, 3'b001);
      tbl[12] = mkv(3'b001, 8'hBB, 1, 1, 1, 3'b001);
      tbl[13] = mkv(3'b000, 8'h00, 0, 0, 0, 3'b000);
      do_reset();
      for (int i = 0; i < 14; i++) begin
         req_valid = tbl[i].rv; req_data = {16'h0, tbl[i].d}; req_eof = {2'b0, tbl[i].eof};
         tx_ready = tbl[i].txr; pcs_locked = 1'b1;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid_eof", i), {tx_valid, tx_eof}, {tbl[i].e_tv, tbl[i].e_eof});
         chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rdy);
         if (tbl[i].e_tv) chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].e_d);
         @(posedge clk); #1;
      end

      // Contention: req0 and req1 both ready from reset.
      do_reset();
      push_frame(0, 8'h10, 3);
      push_frame(1, 8'h20, 3);
      for (int c = 0; c < 20; c++) step(1, 1, 100);
      chk("contention_len", txlog.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < txlog.size()) chk($sformatf("contention_byte%0d", i), txlog[i], exp_c[i]);

      // Backpressure: tx_ready toggling 1010...
      do_reset();
      push_frame(2, 8'h31, 5);
      for (int c = 0; c < 24; c++) step((c % 2) == 0, 1, 100);
      chk("bp_len", txlog.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < txlog.size()) chk($sformatf("bp_byte%0d", i), txlog[i], 8'h31 + 8'(i));
      chk("bp_eofs", obs_eofs, 1);

      // Link down blocks grants; raising it mid-gap takes effect after the gap.
      do_reset();
      push_frame(0, 8'h41, 1);
      for (int c = 0; c < 5; c++) step(1, 0, 100);
      chk("nolink_grant", grant, 3'b000);
      step(1, 1, 100);
      step(1, 1, 100);
      push_frame(1, 8'h51, 1);
      step(1, 0, 100); step(1, 0, 100);
      step(1, 1, 100); step(1, 1, 100); step(1, 1, 100);
      chk("grant_after_gap", grant, 3'b010);
      step(1, 1, 100);
      chk("link_bytes", txlog.size(), 2);

      // Reset mid-frame clears every output immediately.
      do_reset();
      push_frame(0, 8'h61, 5);
      step(1, 1, 100); step(1, 1, 100);
      req_valid = 3'b001; req_data = {16'h0, 8'h62}; req_eof = '0; tx_ready = 1'b1; pcs_locked = 1'b1;
      #1 chk("pre_reset_valid", tx_valid, 1'b1);
      reset_n = 1'b0;
      #1 chk("midreset_outputs", {tx_valid, tx_eof, truncated, tx_data, grant, req_ready}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("post_reset_idle", {grant, tx_valid}, '0);
      @(posedge clk); #1;
      chk("post_reset_regrant", grant, 3'b001);

      // Truncation at MAX_LEN=4, then a normal 4-byte frame (instance with no gap).
      do_reset();
      t_tx_ready = 1'b1;
      t_valid = 2'b10; t_data = {8'hB1, 8'h00}; t_eof = '0;
      @(negedge clk); chk("t_idle_grant", t_grant, 2'b00);
      @(posedge clk); #1;
      for (int j = 0; j < 7; j++) begin
         t_data = {8'hB1 + 8'(j), 8'h00}; t_eof = {(j == 6), 1'b0};
         @(negedge clk);
         chk($sformatf("t_ready%0d", j), {t_ready, t_grant}, 4'b1010);
         if (j < 4) begin
            chk($sformatf("t_out%0d", j), {t_tx_valid, t_tx_eof, t_trunc}, {1'b1, (j == 3), (j == 3)});
            chk($sformatf("t_data%0d", j), t_tx_data, 8'hB1 + 8'(j));
         end else begin
            chk($sformatf("t_drain%0d", j), {t_tx_valid, t_trunc}, 2'b00);
         end
         @(posedge clk); #1;
      end
      t_valid = '0; t_eof = '0;
      @(negedge clk);
      chk("t_after_drain", {t_grant, t_tcount}, {2'b00, 16'd1});
      @(posedge clk); #1;
      t_valid = 2'b01; t_data = {8'h00, 8'hC1};
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin
         t_data = {8'h00, 8'hC1 + 8'(j)}; t_eof = {1'b0, (j == 3)};
         @(negedge clk);
         chk($sformatf("t_full%0d", j), {t_tx_valid, t_tx_eof, t_trunc, t_grant}, {1'b1, (j == 3), 1'b0, 2'b01});
         @(posedge clk); #1;
      end
      t_valid = '0; t_eof = '0;
      @(negedge clk);
      chk("t_full_end", {t_grant, t_tcount}, {2'b00, 16'd1});
      @(posedge clk); #1;

      // Randomized traffic against the reference model.
      do_reset();
      exp_trunc = 0; exp_frames = 0; exp_bytes = 0;
      for (int r = 0; r < N; r++)
         for (int f = 0; f < 6; f++) begin
            len = $urandom_range(12, 1);
            push_frame(r, 8'($urandom), len);
            exp_frames++;
            exp_bytes += (len < ML) ? len : ML;
            if (len > ML) exp_trunc++;
         end
      cyc = 0;
      busy = 1;
      while (busy && cyc < 20000) begin
         step($urandom_range(99) < 75, $urandom_range(99) < 90, 80);
         cyc++;
         busy = (m_owner >= 0) || (m_gap > 0);
         for (int r = 0; r < N; r++) if (srcq[r].size() > 0) busy = 1;
      end
      if (busy) begin
         checks++; errors++;
         $display("FAIL random_timeout: still busy after %0d cycles, required idle", cyc);
      end
      chk("rand_trunc_count", trunc_count, 16'(exp_trunc));
      chk("rand_frames", obs_eofs, exp_frames);
      chk("rand_bytes", txlog.size(), exp_bytes);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of frame requesters, range 2..8.
REQ-002 Parameter MAX_LEN, default 1500: maximum payload bytes per frame before forced truncation, at least 2.
REQ-003 Parameter GAP_CYCLES, default 4: idle cycles inserted after every frame end, 0 allowed.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous assert, active-low reset.
REQ-006 pcs_locked  in  1  link up; gates new grants only.
REQ-007 req_valid  in  NUM_REQ  per-requester byte valid.
REQ-008 req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-009 req_eof  in  NUM_REQ  per-requester last byte of frame, qualified by req_valid.
REQ-010 req_ready  out  NUM_REQ  per-requester byte accepted.
REQ-011 tx_valid / tx_data / tx_eof  out  1/8/1  MAC TX payload stream.
REQ-012 tx_ready  in  1  MAC accepts the current byte.
REQ-013 grant  out  NUM_REQ  one-hot owner of the MAC stream; zero when no owner.
REQ-014 truncated  out  1  one-cycle pulse when a frame is cut at MAX_LEN.
REQ-015 trunc_count  out  16  saturating count of truncated frames.

Function
REQ-016 States: IDLE, PASS, DRAIN, GAP; all outputs are a function of state, grant and inputs, with no combinational path from req_* to grant.
REQ-017 Beat definitions: an output beat is tx_valid && tx_ready; a requester beat is req_valid[i] && req_ready[i].
REQ-018 IDLE: tx_valid=0, req_ready=0; when pcs_locked=1 and any req_valid=1, register the round-robin winner into grant, clear len_cnt, go to PASS.
REQ-019 Round-robin order starts at index (last+1) mod NUM_REQ, where last is the most recently granted requester.
REQ-020 PASS mux: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready; req_ready of every non-granted requester is 0.
REQ-021 PASS tx_eof: tx_eof = tx_valid && (req_eof[g] || len_cnt==MAX_LEN-1).
REQ-022 PASS counting: every output beat increments len_cnt, which is $clog2(MAX_LEN+1) bits wide.
REQ-023 PASS, beat with req_eof[g]=1: last<=g, grant<=0, go to GAP, or to IDLE if GAP_CYCLES=0.
REQ-024 PASS, beat without req_eof at len_cnt==MAX_LEN-1: output tx_eof=1, pulse truncated, increment trunc_count with saturation at 16'hFFFF, go to DRAIN.
REQ-025 DRAIN: tx_valid=0, req_ready[g]=1 and grant held; discard bytes; on a requester beat with req_eof, apply the REQ-023 actions.
REQ-026 GAP: tx_valid=0, req_ready=0; load counter with GAP_CYCLES-1 on entry, go to IDLE when it reaches 0, giving exactly GAP_CYCLES cycles.
REQ-027 Latency: the earliest first output beat is the cycle after req_valid is seen in IDLE.
REQ-028 A frame in progress is never preempted.
REQ-029 pcs_locked falling mid-frame has no effect until frame end.
REQ-030 req_eof on the MAX_LEN-th byte is a normal end, not a truncation.
REQ-031 A requester deasserting req_valid mid-frame holds PASS with tx_valid=0 and no timeout.

Reset
REQ-032 While reset_n=0: state=IDLE, grant=0, tx_valid=0, tx_data=0, tx_eof=0, req_ready=0, truncated=0, trunc_count=0, len_cnt=0, gap counter=0.
REQ-033 last resets to NUM_REQ-1, so requester 0 has first priority.
REQ-034 A reset mid-frame abandons the frame with no tx_eof; deassertion resumes in IDLE.

Structure
REQ-035 The state enum typedef and the byte-width constant belong in the shared package eth_pkg.
REQ-036 Round-robin selection is a sub-module rr_arbiter: combinational, inputs request vector and last index, outputs a one-hot winner.

Verification
REQ-037 Single frame: req0 sends 5 bytes 01..05, tx_ready=1 -> tx_data 01..05 on consecutive cycles, tx_eof on 05, grant=01 then 00, then GAP_CYCLES idle cycles.
REQ-038 Contention: req0 and req1 both valid with 3-byte frames from reset -> req0 frame completes first, then req1 frame, with no byte interleaving.
REQ-039 Truncation: MAX_LEN=4, req1 sends 7 bytes -> 4 bytes output with tx_eof on byte 4, truncated pulse, trunc_count=1, bytes 5-7 accepted with tx_valid=0.
REQ-040 Backpressure: tx_ready toggles 1010... during a frame -> req_ready mirrors tx_ready, with no lost or duplicated bytes.
REQ-041 Link and reset: pcs_locked=0 with req0 valid -> no grant; raise pcs_locked mid-GAP -> grant follows GAP; reset_n pulse mid-frame -> all outputs 0 the same cycle.
